irq_tick_ctrl: RTL

//  Interrupt controller and periodic system tick for the MMU09 SBC. It sits

---
 rtl/irq_tick_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/irq_tick_ctrl.sv
// ---------------------------------------------------------------------------
// irq_tick_ctrl
//
// Interrupt controller and periodic system tick for the MMU09 SBC. It sits
// between the peripheral interrupt pins and the 6809 IRQ/FIRQ inputs.
// Four CPU-visible registers live in the $FE9x I/O window.
//
// Source numbering (pend bits): 0 tick, 1 UART, 2 CH375, 3 RTC.
//
// Register map (i_addr):
//   0 STATUS  R: {any_irq, any_firq, 2'b0, pend[3:0]}
//             W: write-1-to-clear pend[0] and pend[3]
//   1 MASK    R/W bits 3:0 source enables, bits 7:4 read 0
//   2 ROUTE   R/W bits 3:0, 1 = FIRQ, 0 = IRQ (reset 8'h04)
//   3 TICKCNT R tick count; any write clears it
//
// Ports:
//   i_eclk     6809 E clock, all state changes on its rising edge
//   i_reset    synchronous reset, active low
//   i_sel      decoder select for the $FE9x window
//   i_rw       6809 R/W (1 = read, 0 = write)
//   i_addr     register select (A1:A0)
//   i_data     CPU write data
//   o_data     CPU read data (8'h00 while o_doe is low)
//   o_doe      read-data drive enable
//   i_uartirq  UART interrupt, active low level
//   i_chirq    CH375 interrupt, active low level
//   i_rtcirq   RTC interrupt, active low, falling edge is the event
//   irq_n      registered 6809 IRQ, active low
//   firq_n     registered 6809 FIRQ, active low
// ---------------------------------------------------------------------------
module irq_tick_ctrl #(
    parameter int unsigned TICK_DIV = 40000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic       i_eclk,
    input  logic       i_reset,
    input  logic       i_sel,
    input  logic       i_rw,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_doe,
    input  logic       i_uartirq,
    input  logic       i_chirq,
    input  logic       i_rtcirq,
    output logic       irq_n,
    output logic       firq_n
);

    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_MASK    = 2'd1,
        REG_ROUTE   = 2'd2,
        REG_TICKCNT = 2'd3
    } reg_e;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

    // Synchroniser chains: bit 0 is the first stage, bit 1 the second.
    logic [1:0]       uart_sync;
    logic [1:0]       ch_sync;
    logic [1:0]       rtc_sync;

    logic [CNT_W-1:0] div;
    logic             tick_last;

    logic             tick_pend;
    logic             rtc_pend;
    logic             rtc_fall;
    logic [3:0]       pend;

    logic [3:0]       mask;
    logic [3:0]       route;
    logic [7:0]       tick_cnt;

    logic             wr_en;
    logic             wr_status;
    logic             wr_mask;
    logic             wr_route;
    logic             wr_tickcnt;

    logic             any_irq;
    logic             any_firq;
    logic [7:0]       rd_data;

    // Upper write-data bits have no register behind them.
    logic             unused_data;
    assign unused_data = ^i_data[7:4];

    // -----------------------------------------------------------------------
    // Input synchronisers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_eclk) begin
        if (!i_reset) begin
            uart_sync <= '1;
            ch_sync   <= '1;
            rtc_sync  <= '1;
        end else begin
            uart_sync <= {uart_sync[0], i_uartirq};
            ch_sync   <= {ch_sync[0],   i_chirq};
            rtc_sync  <= {rtc_sync[0],  i_rtcirq};
        end
    end

    // Falling edge of the synchronised RTC line, detected on the edge at
    // which the second stage goes low so the RTC keeps the same
    // pin-to-output latency as the level sources.
    assign rtc_fall = rtc_sync[1] & ~rtc_sync[0];

    // -----------------------------------------------------------------------
    // Tick divider
    // -----------------------------------------------------------------------
    assign tick_last = (div == DIV_LAST);

    always_ff @(posedge i_eclk) begin
        if (!i_reset) begin
            div <= '0;
        end else if (tick_last) begin
            div <= '0;
        end else begin
            div <= div + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Register write decode
    // -----------------------------------------------------------------------
    assign wr_en      = i_sel & ~i_rw;
    assign wr_status  = wr_en & (reg_e'(i_addr) == REG_STATUS);
    assign wr_mask    = wr_en & (reg_e'(i_addr) == REG_MASK);
    assign wr_route   = wr_en & (reg_e'(i_addr) == REG_ROUTE);
    assign wr_tickcnt = wr_en & (reg_e'(i_addr) == REG_TICKCNT);

    // -----------------------------------------------------------------------
    // Latched pending bits (tick and RTC). A new event in the same cycle
    // as a write-1-to-clear keeps the bit set.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_eclk) begin
        if (!i_reset) begin
            tick_pend <= 1'b0;
            rtc_pend  <= 1'b0;
        end else begin
            tick_pend <= tick_last | (tick_pend & ~(wr_status & i_data[0]));
            rtc_pend  <= rtc_fall  | (rtc_pend  & ~(wr_status & i_data[3]));
        end
    end

    // UART and CH375 are pure level sources with no latch.
    assign pend = {rtc_pend, ~ch_sync[1], ~uart_sync[1], tick_pend};

    // -----------------------------------------------------------------------
    // MASK, ROUTE, TICKCNT
    // -----------------------------------------------------------------------
    always_ff @(posedge i_eclk) begin
        if (!i_reset) begin
            mask  <= '0;
            route <= 4'h4;
        end else begin
            if (wr_mask) begin
                mask <= i_data[3:0];
            end
            if (wr_route) begin
                route <= i_data[3:0];
            end
        end
    end

    // A clear and a tick in the same cycle leave the count at 1.
    always_ff @(posedge i_eclk) begin
        if (!i_reset) begin
            tick_cnt <= '0;
        end else if (tick_last) begin
            tick_cnt <= (wr_tickcnt ? 8'd0 : tick_cnt) + 8'd1;
        end else if (wr_tickcnt) begin
            tick_cnt <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Interrupt outputs
    // -----------------------------------------------------------------------
    assign any_irq  = |(pend & mask & ~route);
    assign any_firq = |(pend & mask &  route);

    // Both outputs update on the same edge, so a ROUTE change moves an
    // active source from one line to the other without an overlap cycle.
    always_ff @(posedge i_eclk) begin
        if (!i_reset) begin
            irq_n  <= 1'b1;
            firq_n <= 1'b1;
        end else begin
            irq_n  <= ~any_irq;
            firq_n <= ~any_firq;
        end
    end

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    assign o_doe = i_sel & i_rw;

    always_comb begin
        rd_data = '0;
        if (o_doe) begin
            case (reg_e'(i_addr))
                REG_STATUS:  rd_data = {any_irq, any_firq, 2'b00, pend};
                REG_MASK:    rd_data = {4'h0, mask};
                REG_ROUTE:   rd_data = {4'h0, route};
                REG_TICKCNT: rd_data = tick_cnt;
                default:     rd_data = '0;
            endcase
        end
    end

    assign o_data = rd_data;

endmodule
